demux_frame_sequencer: RTL and testbench
========================================

Name: demux_frame_sequencer

Overview:
- Upstream stage of the 1-to-16 demux (oneToSixteen).
- Accepts 16-bit frame words on a valid/ready interface and serialises each word LSB first, one bit per cycle.
- Drives the demux data bit and selector so that, over one frame, output line k of the demux pulses exactly when word bit k is 1.
- Adds a pause input, a frame-done strobe and back-to-back frame acceptance.

Parameters:
- NUM_CH, 16, number of demux channels; equals the frame word width.
- SEL_W, 4, selector width; must satisfy 2**SEL_W == NUM_CH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  NUM_CH  frame word; bit k is destined for channel k.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  sequencer accepts a word this cycle.
- pause  input  1  freezes sequencing while high.
- bit_out  output  1  serial bit; connects to the demux data input.
- selector  output  SEL_W  channel index; connects to the demux selector.
- bit_valid  output  1  bit_out/selector carry a frame bit this cycle.
- frame_done  output  1  one-cycle strobe on the last emitted bit of a frame.

Behaviour:
- Reset: clk/rst as above; rst synchronous, active-high. While rst=1 at a rising edge:
  - state goes to IDLE;
  - bit_out=0, selector=0, bit_valid=0, frame_done=0;
  - the shift register clears.
  - rst asserted mid-frame aborts the frame: remaining bits are discarded and no frame_done is produced.
- States:
  - IDLE: no frame in flight.
  - SHIFT: a frame is being serialised.
- Handshake:
  - Transfer occurs when s_valid and s_ready are both 1 at a rising edge.
  - s_ready = !pause && (state==IDLE || (state==SHIFT && last bit this cycle)).
  - s_ready is combinational from state and pause only, never from s_valid.
  - s_data is sampled only on transfer; s_data changes at other times are ignored.
- Latency: the first bit appears the cycle after the transfer, with bit_valid=1, selector=0 and bit_out=s_data[0].
- SHIFT progression, each unpaused cycle:
  - selector increments by 1 and bit_out = word[selector];
  - after selector=NUM_CH-1 (the last bit, with frame_done=1 in the same cycle):
    - if a transfer happened on that edge, the next cycle is selector=0 with the new word[0] (zero-bubble back-to-back);
    - otherwise the block enters IDLE.
- Outputs in IDLE: bit_valid=0, bit_out=0 (so every demux output is 0), selector=0.
- bit_out is forced to 0 whenever bit_valid=0.
- Pause:
  - While pause=1, selector, bit_out, bit_valid and the word hold their values.
  - frame_done is 0 during pause, even if pause is asserted on the last bit; the strobe is then issued on the first unpaused cycle at that bit.
  - Note: with pause held, bit_valid stays 1 and the demux output stays asserted. Downstream treats a repeated bit as a single event by qualifying on pause.
  - pause and s_valid together: no transfer, because s_ready=0.
- Selector arithmetic: SEL_W-bit unsigned; no wrap is ever emitted mid-frame, because the frame ends at NUM_CH-1.
- Simultaneous rst and s_valid: rst wins; the word is dropped.
- frame_done is asserted only together with bit_valid=1, or per the skip-zero rule below.

Optional Feature:
- Macro: DEMUX_SEQ_SKIPZERO_EN.
- Defined:
  - Only set bits are emitted. selector jumps directly to the next set bit index above the current one, using a priority search.
  - bit_out=1 on every bit_valid cycle.
  - The last bit is the highest set bit; s_ready rules apply at that bit.
  - A zero word is accepted normally and emits no bit_valid cycles. frame_done pulses in the cycle after transfer with bit_valid=0, and s_ready=1 in that cycle.
- Undefined: all NUM_CH bits are emitted, including zeros, exactly as described above.

Test Plan:
- Reset, then s_data=16'hA5A5 with s_valid pulsed 1 cycle -> cycles 1..16: selector 0..15, bit_out=1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1; frame_done only at selector=15; IDLE at cycle 17.
- Back-to-back: 16'hFFFF then 16'h0001 with s_valid held -> s_ready high only at selector=15; second frame selector=0 bit_out=1 the very next cycle; 32 consecutive bit_valid cycles.
- pause=1 for 3 cycles at selector=7, then pause=1 at selector=15 -> selector holds 7 for 3 cycles; frame_done suppressed during pause and then issued once; total frame spans 16+3+pause cycles.
- rst=1 at selector=9 of 16'hFFFF -> next cycle all outputs 0, no frame_done; a new word accepted the cycle after rst drops starts at selector=0.
- s_data changes while not ready -> the emitted bits match the word captured at transfer.
- With DEMUX_SEQ_SKIPZERO_EN, word 16'h8011 -> 3 bit_valid cycles, selector 0,4,15; frame_done at 15. Word 16'h0000 -> frame_done 1 cycle after transfer, bit_valid never 1.

Source files
------------

// File: rtl/demux_frame_sequencer.sv
// Serialises 16-bit frame words LSB first into bit/selector pairs for the 1-to-16 demux.
// Optional build macro DEMUX_SEQ_SKIPZERO_EN: emit only the set bits of each word.
module demux_frame_sequencer #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              pause,
  output logic              bit_out,
  output logic [SEL_W-1:0]  selector,
  output logic              bit_valid,
  output logic              frame_done
);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [NUM_CH-1:0] sreg_r, sreg_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic              bit_r, bit_s;
  logic              valid_r, valid_s;
  logic              last_s;
  logic              xfer_s;

`ifdef DEMUX_SEQ_SKIPZERO_EN
  logic              zdone_r, zdone_s;

  // Priority search: index of the lowest set bit (0 when the word is empty).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] w);
    lowest_set = {SEL_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w[i]) lowest_set = SEL_W'(i);
      else      lowest_set = lowest_set;
    end
  endfunction

  // Clears the lowest set bit, i.e. marks that bit as emitted.
  function automatic logic [NUM_CH-1:0] clear_lowest(input logic [NUM_CH-1:0] w);
    clear_lowest = w & (w - NUM_CH'(1));
  endfunction

  // sreg_r holds the not-yet-emitted set bits, so an empty mask marks the last bit.
  assign last_s     = (state_r == SHIFT) && (sreg_r == {NUM_CH{1'b0}});
  assign frame_done = (last_s || zdone_r) && !pause;
`else
  assign last_s     = (state_r == SHIFT) && (sel_r == SEL_W'(NUM_CH - 1));
  assign frame_done = last_s && !pause;
`endif

  assign s_ready   = !pause && ((state_r == IDLE) || last_s);
  assign xfer_s    = s_valid && s_ready;
  assign selector  = sel_r;
  assign bit_valid = valid_r;
  assign bit_out   = bit_r & valid_r;

  // Next-state: hold on pause, load on transfer, advance mid-frame, otherwise idle.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    sel_s   = sel_r;
    bit_s   = bit_r;
    valid_s = valid_r;
`ifdef DEMUX_SEQ_SKIPZERO_EN
    zdone_s = zdone_r;
`endif
    if (pause) begin
      state_s = state_r;
    end else begin
`ifdef DEMUX_SEQ_SKIPZERO_EN
      zdone_s = 1'b0;
      if (xfer_s) begin
        if (s_data == {NUM_CH{1'b0}}) begin
          // An empty word is still a frame: it completes with no bit cycles.
          state_s = IDLE;
          sreg_s  = {NUM_CH{1'b0}};
          sel_s   = {SEL_W{1'b0}};
          bit_s   = 1'b0;
          valid_s = 1'b0;
          zdone_s = 1'b1;
        end else begin
          state_s = SHIFT;
          sreg_s  = clear_lowest(s_data);
          sel_s   = lowest_set(s_data);
          bit_s   = 1'b1;
          valid_s = 1'b1;
        end
      end else if ((state_r == SHIFT) && !last_s) begin
        sreg_s = clear_lowest(sreg_r);
        sel_s  = lowest_set(sreg_r);
        bit_s  = 1'b1;
      end else begin
        state_s = IDLE;
        sreg_s  = {NUM_CH{1'b0}};
        sel_s   = {SEL_W{1'b0}};
        bit_s   = 1'b0;
        valid_s = 1'b0;
      end
`else
      if (xfer_s) begin
        state_s = SHIFT;
        sreg_s  = {1'b0, s_data[NUM_CH-1:1]};
        sel_s   = {SEL_W{1'b0}};
        bit_s   = s_data[0];
        valid_s = 1'b1;
      end else if ((state_r == SHIFT) && !last_s) begin
        sreg_s = {1'b0, sreg_r[NUM_CH-1:1]};
        sel_s  = sel_r + SEL_W'(1);
        bit_s  = sreg_r[0];
      end else begin
        state_s = IDLE;
        sreg_s  = {NUM_CH{1'b0}};
        sel_s   = {SEL_W{1'b0}};
        bit_s   = 1'b0;
        valid_s = 1'b0;
      end
`endif
    end
  end

  // State and output registers with synchronous reset (reset drops any frame in flight).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sreg_r  <= {NUM_CH{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
`ifdef DEMUX_SEQ_SKIPZERO_EN
      zdone_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      sel_r   <= sel_s;
      bit_r   <= bit_s;
      valid_r <= valid_s;
`ifdef DEMUX_SEQ_SKIPZERO_EN
      zdone_r <= zdone_s;
`endif
    end
  end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed, table-driven bench for demux_frame_sequencer (default build: all bits emitted).
module tb_demux_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, s_valid, pause;
  logic [15:0] s_data;
  logic        s_ready, bit_out, bit_valid, frame_done;
  logic [3:0]  selector;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .pause     (pause),
    .bit_out   (bit_out),
    .selector  (selector),
    .bit_valid (bit_valid),
    .frame_done(frame_done)
  );

  // exp packs {s_ready, bit_out, selector[3:0], bit_valid, frame_done}
  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic        pause;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] pk(logic rdy, logic b, logic [3:0] sel, logic v, logic d);
    return {rdy, b, sel, v, d};
  endfunction

  task automatic add(logic r, logic v, logic [15:0] d, logic p, logic [7:0] e, string n);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.pause = p; t.exp = e; t.name = n;
    vecs.push_back(t);
  endtask

  // One frame of word w, optionally with pause cycles inserted at selector 7 and 15.
  task automatic add_frame(logic [15:0] w, logic v_mid, logic [15:0] d_mid,
                           logic v_last, logic [15:0] d_last, int p7, int p15, string n);
    for (int k = 0; k < 16; k++) begin
      if (k == 7)
        for (int j = 0; j < p7; j++) add(1'b0, v_mid, d_mid, 1'b1, pk(1'b0, w[7], 4'd7, 1'b1, 1'b0), {n, "_pause7"});
      if (k == 15)
        for (int j = 0; j < p15; j++) add(1'b0, 1'b1, d_mid, 1'b1, pk(1'b0, w[15], 4'd15, 1'b1, 1'b0), {n, "_pause15"});
      add(1'b0, (k == 15) ? v_last : v_mid, (k == 15) ? d_last : d_mid, 1'b0,
          pk(k == 15, w[k], 4'(k), 1'b1, k == 15), {n, "_bit"});
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare outputs before the rising edge.
  task automatic step(vec_t t);
    logic [7:0] act;
    @(negedge clk);
    rst = t.rst; s_valid = t.valid; s_data = t.data; pause = t.pause;
    #1;
    act = {s_ready, bit_out, selector, bit_valid, frame_done};
    checks++;
    if (act !== t.exp) begin
      failures++;
      $display("FAIL %s: got {rdy,bit,sel,vld,done}=%b want %b", t.name, act, t.exp);
    end
  endtask

  task automatic step_v(logic r, logic v, logic [15:0] d, logic p, logic [7:0] e, string n);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.pause = p; t.exp = e; t.name = n;
    step(t);
  endtask

  localparam logic [7:0] IDLE_EXP = 8'b1_0_0000_0_0;

  initial begin
    logic [15:0] w;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; pause = 1'b0;
    repeat (2) @(posedge clk);

    add(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "reset_idle");
    add(1'b0, 1'b1, 16'hDEAD, 1'b1, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), "pause_blocks_ready");
    add(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "no_xfer_while_paused");

    add(1'b0, 1'b1, 16'hA5A5, 1'b0, IDLE_EXP, "a5a5_xfer");
    add_frame(16'hA5A5, 1'b1, 16'h1234, 1'b0, 16'hFFFF, 0, 0, "a5a5");
    add(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "a5a5_idle");

    add(1'b0, 1'b1, 16'hFFFF, 1'b0, IDLE_EXP, "b2b_xfer");
    add_frame(16'hFFFF, 1'b1, 16'h0001, 1'b1, 16'h0001, 0, 0, "b2b_ffff");
    add_frame(16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0, "b2b_0001");
    add(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "b2b_idle");

    add(1'b0, 1'b1, 16'h3C5A, 1'b0, IDLE_EXP, "pause_xfer");
    add_frame(16'h3C5A, 1'b0, 16'h0000, 1'b0, 16'h0000, 3, 2, "pause");
    add(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "pause_idle");

    foreach (vecs[i]) step(vecs[i]);

    // Reset in mid-frame aborts without frame_done; next word restarts at selector 0.
    w = 16'hFFFF;
    step_v(1'b0, 1'b1, w, 1'b0, IDLE_EXP, "rst_xfer");
    for (int k = 0; k < 9; k++)
      step_v(1'b0, 1'b0, 16'h0000, 1'b0, pk(1'b0, 1'b1, 4'(k), 1'b1, 1'b0), "rst_pre_bit");
    step_v(1'b1, 1'b0, 16'h0000, 1'b0, pk(1'b0, 1'b1, 4'd9, 1'b1, 1'b0), "rst_at_sel9");
    w = 16'h0003;
    step_v(1'b0, 1'b1, w, 1'b0, IDLE_EXP, "rst_abort_idle");
    for (int k = 0; k < 16; k++)
      step_v(1'b0, 1'b0, 16'h0000, 1'b0, pk(k == 15, w[k], 4'(k), 1'b1, k == 15), "post_rst_bit");
    step_v(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "post_rst_idle");

    // Reset together with s_valid: reset wins, word is dropped.
    step_v(1'b1, 1'b1, 16'hFFFF, 1'b0, IDLE_EXP, "rst_with_valid");
    step_v(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "rst_wins_idle");
    step_v(1'b0, 1'b0, 16'h0000, 1'b0, IDLE_EXP, "rst_wins_idle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
